// File: rtl/row_result_serializer.sv
// row_result_serializer
// Captures packed 2W-bit dot-product vectors from the row multiplier,
// requantizes each element to W bits (round half up, arithmetic shift,
// saturate), and streams them one element per transfer on a valid/ready port.
// A pending slot absorbs one extra vector while the active one drains.
// Further arrivals are dropped and reported through the sticky overflow flag.

module row_result_serializer #(
    parameter  int W     = 16,
    parameter  int D     = 8,
    parameter  int SHIFT = 8,
    localparam int IW    = (D > 1) ? $clog2(D) : 1,
    localparam int EW    = 2 * W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*D*W-1:0]  packed_in,
    input  logic              in_v,
    output logic [W-1:0]      out_data,
    output logic [IW-1:0]     out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Rounding constant 2^(SHIFT-1), written so SHIFT = 0 yields zero without a negative shift.
    localparam logic signed [EW:0] C_ROUND = ((EW+1)'(1) << SHIFT) >>> 1;
    localparam logic signed [EW:0] C_MAX   = (EW+1)'((2 ** (W - 1)) - 1);
    localparam logic signed [EW:0] C_MIN   = ~C_MAX;
    localparam logic [IW-1:0]      C_LAST  = IW'(D - 1);

    state_t             r_state;
    logic [2*D*W-1:0]   r_active;
    logic [2*D*W-1:0]   r_pending;
    logic               r_pend_v;
    logic [IW-1:0]      r_idx;
    logic               r_overflow;

    logic [EW-1:0]      w_elem [D];
    logic [EW-1:0]      w_sel;
    logic signed [EW:0] w_ext;
    logic signed [EW:0] w_sum;
    logic signed [EW:0] w_shr;
    logic               w_xfer;
    logic               w_is_last;

    // Slice the active vector into elements; element 0 is the most significant slice.
    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_elem
            assign w_elem[gi] = r_active[(D-gi)*EW-1 -: EW];
        end
    endgenerate

    // Requantize the currently indexed element; one extra bit keeps the rounding add from wrapping.
    always_comb begin
        w_sel = w_elem[r_idx];
        w_ext = {w_sel[EW-1], w_sel};
        w_sum = w_ext + C_ROUND;
        w_shr = w_sum >>> SHIFT;
        if (w_shr > C_MAX) begin
            out_data = C_MAX[W-1:0];
        end else if (w_shr < C_MIN) begin
            out_data = C_MIN[W-1:0];
        end else begin
            out_data = w_shr[W-1:0];
        end
    end

    assign w_xfer    = (r_state == ST_EMIT) && out_ready;
    assign w_is_last = (r_idx == C_LAST);

    assign out_idx   = r_idx;
    assign out_valid = (r_state == ST_EMIT);
    assign out_last  = (r_state == ST_EMIT) && w_is_last;
    assign busy      = (r_state == ST_EMIT);
    assign overflow  = r_overflow;

    // Slot management, element sequencing and overflow tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_active   <= '0;
            r_pending  <= '0;
            r_pend_v   <= 1'b0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_v) begin
                        r_active <= packed_in;
                        r_idx    <= '0;
                        r_state  <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_xfer && !w_is_last) begin
                        r_idx <= r_idx + IW'(1);
                    end else if (w_xfer && w_is_last) begin
                        if (r_pend_v) begin
                            // Promote the queued vector with no bubble; pending slot frees up.
                            r_active <= r_pending;
                            r_pend_v <= 1'b0;
                            r_idx    <= '0;
                        end else if (in_v) begin
                            // Nothing queued: the arriving vector goes straight to active.
                            r_active <= packed_in;
                            r_idx    <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_idx   <= '0;
                        end
                    end

                    // Arrival while emitting: queue it, unless it was already taken into active.
                    if (in_v && !(w_xfer && w_is_last && !r_pend_v)) begin
                        if (!r_pend_v || (w_xfer && w_is_last)) begin
                            r_pending <= packed_in;
                            r_pend_v  <= 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_result_serializer.sv
// Directed testbench for row_result_serializer (W=16, D=4, SHIFT=8).
// Expected element values are hand-computed constants.

module tb_row_result_serializer;

    localparam int W     = 16;
    localparam int D     = 4;
    localparam int SHIFT = 8;
    localparam int IW    = 2;

    logic              clk;
    logic              rst;
    logic [2*D*W-1:0]  packed_in;
    logic              in_v;
    logic [W-1:0]      out_data;
    logic [IW-1:0]     out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              overflow;

    int n_checks;
    int n_errors;
    int cyc;
    int cyc_cap;

    int q_data [$];
    int q_idx  [$];
    int q_last [$];
    int q_cyc  [$];
    int e_data [$];
    int e_idx  [$];

    row_result_serializer #(.W(W), .D(D), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .packed_in (packed_in),
        .in_v      (in_v),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer monitor: logs every accepted element with its cycle stamp.
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(int'($signed(out_data)));
            q_idx.push_back(int'(out_idx));
            q_last.push_back(int'(out_last));
            q_cyc.push_back(cyc);
            $display("xfer cyc=%0d idx=%0d data=%0d last=%0d", cyc, out_idx, $signed(out_data), out_last);
        end
        cyc++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*D*W-1:0] pk(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d);
        return {a, b, c, d};
    endfunction

    task automatic clr();
        q_data.delete(); q_idx.delete(); q_last.delete(); q_cyc.delete();
        e_data.delete(); e_idx.delete();
    endtask

    task automatic exp_vec(input int v0, input int v1, input int v2, input int v3);
        e_data.push_back(v0); e_idx.push_back(0);
        e_data.push_back(v1); e_idx.push_back(1);
        e_data.push_back(v2); e_idx.push_back(2);
        e_data.push_back(v3); e_idx.push_back(3);
    endtask

    // Compare the transfer log against the expected element list.
    task automatic cmp_log(input string tag, input bit consec);
        int n;
        chk({tag, "_count"}, q_data.size(), e_data.size());
        n = (q_data.size() < e_data.size()) ? q_data.size() : e_data.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), q_data[i], e_data[i]);
            chk($sformatf("%s_idx%0d", tag, i), q_idx[i], e_idx[i]);
            chk($sformatf("%s_last%0d", tag, i), q_last[i], (e_idx[i] == D - 1) ? 1 : 0);
            if (consec && i > 0)
                chk($sformatf("%s_gap%0d", tag, i), q_cyc[i] - q_cyc[i-1], 1);
        end
        clr();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [2*D*W-1:0] vec_a, vec_b, vec_c, vec_d, vec_e;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_v      = 1'b0;
        out_ready = 1'b0;
        packed_in = '0;
        vec_a = pk(32'h0000_0180, 32'hFFFF_FF80, 32'h7FFF_FFFF, 32'h8000_0000); //  2, 0, 32767, -32768
        vec_b = pk(32'h0000_0100, 32'h0000_017F, 32'h0000_0180, 32'hFFFF_FE7F); //  1, 1, 2, -2
        vec_c = pk(32'h0000_0A00, 32'h0000_0B00, 32'h0000_0C00, 32'h0000_0D00); // 10,11,12,13
        vec_d = pk(32'h0000_1400, 32'h0000_1500, 32'h0000_1600, 32'h0000_1700); // 20,21,22,23
        vec_e = pk(32'hFFFF_F000, 32'h00FF_FF00, 32'h0000_7F80, 32'h0000_0000); // -16,32767,128,0

        // Reset state
        tick(); tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_data", int'($signed(out_data)), 0);
        rst = 1'b0;
        tick();
        clr();

        // Requantization and index/last sequencing
        out_ready = 1'b1;
        packed_in = vec_a; in_v = 1'b1;
        tick();
        in_v = 1'b0;
        chk("rq_valid0", int'(out_valid), 1);
        chk("rq_data0", int'($signed(out_data)), 2);
        chk("rq_last0", int'(out_last), 0);
        repeat (5) tick();
        chk("rq_idle", int'(out_valid), 0);
        exp_vec(2, 0, 32767, -32768);
        cmp_log("rq", 1'b1);

        // Backpressure at idx 1
        packed_in = vec_b; in_v = 1'b1;
        tick();
        in_v = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_idx%0d", k), int'(out_idx), 1);
            chk($sformatf("bp_data%0d", k), int'($signed(out_data)), 1);
            chk($sformatf("bp_valid%0d", k), int'(out_valid), 1);
        end
        out_ready = 1'b1;
        repeat (5) tick();
        exp_vec(1, 1, 2, -2);
        cmp_log("bp", 1'b0);

        // Back-to-back vectors
        packed_in = vec_c; in_v = 1'b1;
        tick();
        cyc_cap = cyc;
        packed_in = vec_d;
        tick();
        in_v = 1'b0;
        repeat (9) tick();
        chk("b2b_lat", q_cyc.size() > 0 ? q_cyc[0] : -1, cyc_cap);
        chk("b2b_ovf", int'(overflow), 0);
        exp_vec(10, 11, 12, 13);
        exp_vec(20, 21, 22, 23);
        cmp_log("b2b", 1'b1);

        // Overflow: third vector dropped while ready is low
        out_ready = 1'b0;
        packed_in = vec_c; in_v = 1'b1;
        tick();
        packed_in = vec_d;
        tick();
        chk("ovf_pre", int'(overflow), 0);
        packed_in = vec_e;
        tick();
        in_v = 1'b0;
        chk("ovf_set", int'(overflow), 1);
        tick();
        chk("ovf_hold", int'(overflow), 1);
        out_ready = 1'b1;
        repeat (12) tick();
        chk("ovf_sticky", int'(overflow), 1);
        exp_vec(10, 11, 12, 13);
        exp_vec(20, 21, 22, 23);
        cmp_log("ovf", 1'b1);
        do_reset();
        chk("ovf_clr", int'(overflow), 0);
        clr();

        // Last-element transfer with in_v, pending empty
        packed_in = vec_c; in_v = 1'b1;
        tick();
        in_v = 1'b0;
        repeat (3) tick();
        chk("sim1_at_last", int'(out_last), 1);
        packed_in = vec_e; in_v = 1'b1;
        tick();
        in_v = 1'b0;
        chk("sim1_idx", int'(out_idx), 0);
        chk("sim1_valid", int'(out_valid), 1);
        repeat (6) tick();
        chk("sim1_done", int'(out_valid), 0);
        exp_vec(10, 11, 12, 13);
        exp_vec(-16, 32767, 128, 0);
        cmp_log("sim1", 1'b1);

        // Last-element transfer with in_v, pending full
        packed_in = vec_c; in_v = 1'b1;
        tick();
        packed_in = vec_d;
        tick();
        in_v = 1'b0;
        tick();
        tick();
        chk("sim2_at_last", int'(out_last), 1);
        packed_in = vec_e; in_v = 1'b1;
        tick();
        in_v = 1'b0;
        repeat (11) tick();
        chk("sim2_ovf", int'(overflow), 0);
        chk("sim2_done", int'(out_valid), 0);
        exp_vec(10, 11, 12, 13);
        exp_vec(20, 21, 22, 23);
        exp_vec(-16, 32767, 128, 0);
        cmp_log("sim2", 1'b1);

        // Asynchronous reset mid-vector, with a vector queued
        packed_in = vec_c; in_v = 1'b1;
        tick();
        packed_in = vec_d;
        tick();
        in_v = 1'b0;
        tick();
        chk("mrst_pre_idx", int'(out_idx), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid", int'(out_valid), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_idx", int'(out_idx), 0);
        chk("mrst_data", int'($signed(out_data)), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr();
        repeat (6) tick();
        chk("mrst_quiet_cnt", q_data.size(), 0);
        chk("mrst_quiet_valid", int'(out_valid), 0);
        packed_in = vec_e; in_v = 1'b1;
        tick();
        in_v = 1'b0;
        chk("mrst_new_idx", int'(out_idx), 0);
        chk("mrst_new_data", int'($signed(out_data)), -16);
        repeat (6) tick();
        exp_vec(-16, 32767, 128, 0);
        cmp_log("mrst", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
